// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads a combinational instruction
// memory, and buffers fetched words in a 2-entry FIFO toward decode.
`timescale 1ns/1ps
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 32,
  parameter int          ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              fault,
  output logic [31:0]       fault_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_DEPTH * 4);

  state_t      state_r, state_s;
  logic [31:0] pc_r;
  logic        head_v_r, tail_v_r;
  logic [31:0] head_pc_r, head_instr_r, tail_pc_r, tail_instr_r;
  logic        fault_r;
  logic [31:0] fault_pc_r;

  logic pc_illegal_s, attempt_s, pop_s, room_s, push_s, fault_now_s;

  assign imem_addr = pc_r[ADDR_W+1:2];
  assign out_valid = head_v_r;
  assign out_pc    = head_pc_r;
  assign out_instr = head_instr_r;
  assign fault     = fault_r;
  assign fault_pc  = fault_pc_r;

  // Fetch/pop qualifiers; a redirect suppresses both push and pop.
  always_comb begin
    pc_illegal_s = (pc_r[1:0] != 2'b00) || (pc_r >= PC_LIMIT);
    attempt_s    = (state_r == ST_RUN) && enable && !redirect_valid;
    pop_s        = head_v_r && out_ready && !redirect_valid;
    room_s       = !tail_v_r || pop_s;
    push_s       = attempt_s && !pc_illegal_s && room_s;
    fault_now_s  = attempt_s && pc_illegal_s;
  end

  // Next-state logic for the fetch controller.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (redirect_valid) state_s = ST_IDLE;
        else if (enable)    state_s = ST_RUN;
        else                state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (redirect_valid)    state_s = ST_RUN;
        else if (!enable)      state_s = ST_IDLE;
        else if (pc_illegal_s) state_s = ST_HALT;
        else                   state_s = ST_RUN;
      end
      ST_HALT: begin
        if (redirect_valid) state_s = ST_RUN;
        else                state_s = ST_HALT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Program counter: redirect wins, otherwise advance on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc_r <= RESET_PC;
    else if (redirect_valid) pc_r <= redirect_pc;
    else if (push_s)         pc_r <= pc_r + 32'd4;
    else                     pc_r <= pc_r;
  end

  // Sticky fault; only a redirect (or reset) clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_r    <= 1'b0;
      fault_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      fault_r    <= 1'b0;
      fault_pc_r <= fault_pc_r;
    end else if (fault_now_s) begin
      fault_r    <= 1'b1;
      fault_pc_r <= pc_r;
    end else begin
      fault_r    <= fault_r;
      fault_pc_r <= fault_pc_r;
    end
  end

  // Two-entry FIFO: head drives out_*, tail is only valid behind a valid head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v_r     <= 1'b0;
      tail_v_r     <= 1'b0;
      head_pc_r    <= 32'h0000_0000;
      head_instr_r <= 32'h0000_0000;
      tail_pc_r    <= 32'h0000_0000;
      tail_instr_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      head_v_r <= 1'b0;
      tail_v_r <= 1'b0;
    end else if (pop_s && push_s) begin
      if (tail_v_r) begin
        head_pc_r    <= tail_pc_r;
        head_instr_r <= tail_instr_r;
        tail_pc_r    <= pc_r;
        tail_instr_r <= imem_rdata;
      end else begin
        head_pc_r    <= pc_r;
        head_instr_r <= imem_rdata;
      end
    end else if (pop_s) begin
      head_v_r     <= tail_v_r;
      head_pc_r    <= tail_pc_r;
      head_instr_r <= tail_instr_r;
      tail_v_r     <= 1'b0;
    end else if (push_s) begin
      if (!head_v_r) begin
        head_v_r     <= 1'b1;
        head_pc_r    <= pc_r;
        head_instr_r <= imem_rdata;
      end else begin
        tail_v_r     <= 1'b1;
        tail_pc_r    <= pc_r;
        tail_instr_r <= imem_rdata;
      end
    end else begin
      head_v_r <= head_v_r;
      tail_v_r <= tail_v_r;
    end
  end

endmodule
